disp_mux_param: RTL and testbench

Parametrised successor to the fixed 4-digit display multiplexer plus its external digit registers. It holds N_DIG digit patterns internally, loaded through a write port in either hex-decode or raw-segment mode. It time-multiplexes the patterns onto a common-anode seven-segment display and adds per-digit blanking, PWM brightness and a frame tick. It sits between board I/O (switch/button glue or a CPU register) and the sseg/an pins.

---
 rtl/disp_mux_param_pkg.sv | 36 +++
 rtl/disp_mux_param_if.sv | 21 ++
 rtl/disp_mux_param_hex_to_sseg.sv | 13 +
 rtl/disp_mux_param.sv | 104 ++++++++++
 tb/tb_disp_mux_param.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/disp_mux_param_pkg.sv
// Shared constants and helpers for the parametrised display multiplexer.
//   SSEG_OFF : all segments dark (active-low)
//   hex7()   : nibble -> 7-bit active-low gfedcba pattern
//   idx_w()  : width of a digit index for a given digit count
package disp_pkg;

  localparam logic [7:0] SSEG_OFF = 8'hFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/disp_mux_param_if.sv
// Digit-store write port.
//   wr_en    : write strobe
//   wr_addr  : digit index
//   wr_data  : hex nibble + dp, or raw active-low pattern
//   hex_mode : 1 = decode wr_data as hex
// master drives the port (CPU / switch glue), slave is the display block.
interface disp_mux_param_if
  import disp_pkg::*;
#(
  parameter int N_DIG = 4
);
  localparam int IDX_W = idx_w(N_DIG);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             hex_mode;

  modport master (output wr_en, output wr_addr, output wr_data, output hex_mode);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  hex_mode);
endinterface

// File: rtl/disp_mux_param_hex_to_sseg.sv
// Combinational hex nibble + decimal point to active-low {dp,g..a} pattern.
//   nibble : hex digit
//   dp     : 1 = decimal point lit
//   sseg   : active-low segment pattern
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] sseg
);
  assign sseg = {~dp, hex7(nibble)};
endmodule

// File: rtl/disp_mux_param.sv
// Time-multiplexed common-anode seven-segment driver with internal digit
// store, per-digit blanking, PWM brightness and a frame tick.
//   clk, rst   : clock, async active-low reset
//   wr         : digit-store write port (slave)
//   blank      : 1 = force digit dark
//   bright     : PWM duty level, 0 = off, all-ones = full
//   sseg, an   : active-low segments and anodes (registered)
//   frame_tick : one-cycle pulse aligned with first output of digit 0
module disp_mux_param
  import disp_pkg::*;
#(
  parameter int N_DIG    = 4,
  parameter int PRESC_W  = 16,
  parameter int BRIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  disp_mux_param_if.slave     wr,
  input  logic [N_DIG-1:0]    blank,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [7:0]          sseg,
  output logic [N_DIG-1:0]    an,
  output logic                frame_tick
);
  localparam int IDX_W = idx_w(N_DIG);

  logic [7:0]         store_q [N_DIG];
  logic [7:0]         store_d [N_DIG];
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sseg_q, sseg_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic               tick_q, tick_d;

  logic [7:0] hex_pat;
  logic [7:0] wr_pat;
  logic       addr_ok;
  logic       lit;

  hex_to_sseg u_hex (
    .nibble (wr.wr_data[3:0]),
    .dp     (wr.wr_data[4]),
    .sseg   (hex_pat)
  );

  // Decode once at write time so a later hex_mode change leaves stored digits alone.
  assign wr_pat  = wr.hex_mode ? hex_pat : wr.wr_data;
  // Extra bit keeps the compare correct when N_DIG is a power of two.
  assign addr_ok = ({1'b0, wr.wr_addr} < (IDX_W+1)'(N_DIG));

  always_comb begin
    store_d = store_q;
    if (wr.wr_en && addr_ok) begin
      store_d[wr.wr_addr] = wr_pat;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (&presc_q) begin
      idx_d = (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // PWM: compare the prescaler's top bits so each slot splits into
  // 2^BRIGHT_W equal sub-periods; all-ones forces full duty.
  assign lit = !blank[idx_q] &&
               ((presc_q[PRESC_W-1 -: BRIGHT_W] < bright) || (&bright));

  always_comb begin
    sseg_d = SSEG_OFF;
    an_d   = '1;
    if (lit) begin
      sseg_d = store_q[idx_q];
      an_d   = ~(N_DIG'(1) << idx_q);
    end
    // Registered alongside digit 0's first output.
    tick_d = (idx_q == '0) && (presc_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_q <= '{default: SSEG_OFF};
      presc_q <= '0;
      idx_q   <= '0;
      sseg_q  <= SSEG_OFF;
      an_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      store_q <= store_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sseg_q  <= sseg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign sseg       = sseg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_mux_param.sv
module tb_disp_mux_param;
  localparam int N_DIG    = 3;
  localparam int PRESC_W  = 4;
  localparam int BRIGHT_W = 2;

  logic                clk;
  logic                rst;
  logic [N_DIG-1:0]    blank;
  logic [BRIGHT_W-1:0] bright;
  logic [7:0]          sseg;
  logic [N_DIG-1:0]    an;
  logic                frame_tick;

  int n_checks = 0;
  int n_err    = 0;

  disp_mux_param_if #(.N_DIG(N_DIG)) wr_if ();

  disp_mux_param #(
    .N_DIG    (N_DIG),
    .PRESC_W  (PRESC_W),
    .BRIGHT_W (BRIGHT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .blank      (blank),
    .bright     (bright),
    .sseg       (sseg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where frame_tick is seen (scan position 0).
  task automatic wait_tick(input string tag);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic wr_digit(input logic [1:0] a, input logic [7:0] d, input logic h);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    wr_if.hex_mode = h;
    @(negedge clk);
    wr_if.wr_en    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lit;
    int ticks;
    int first;
    bit two_low;

    rst            = 1'b0;
    blank          = '0;
    bright         = 2'd3;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    wr_if.hex_mode = 1'b0;

    // Reset state
    step(3);
    chk("rst_an",   an,         3'b111);
    chk("rst_sseg", sseg,       8'hFF);
    chk("rst_tick", frame_tick, 1'b0);
    rst = 1'b1;
    step(1);
    chk("post_rst_tick", frame_tick, 1'b1);
    chk("post_rst_an",   an,         3'b110);
    chk("post_rst_sseg", sseg,       8'hFF);
    step(1);
    chk("post_rst_tick_low", frame_tick, 1'b0);

    // Async reset mid-scan
    step(20);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_an",   an,         3'b111);
    chk("mid_rst_sseg", sseg,       8'hFF);
    chk("mid_rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_tick("tick_after_mid_rst");
    chk("mid_rst_restart_an", an, 3'b110);

    // Hex writes
    wr_digit(2'd0, 8'h05, 1'b1);
    wr_digit(2'd2, 8'h1A, 1'b1);
    wait_tick("tick_hex");
    chk("hex_s0_an",   an,   3'b110);
    chk("hex_s0_sseg", sseg, 8'h92);
    step(16);
    chk("hex_s1_an",   an,   3'b101);
    chk("hex_s1_sseg", sseg, 8'hFF);
    step(16);
    chk("hex_s2_an",   an,   3'b011);
    chk("hex_s2_sseg", sseg, 8'h08);
    step(16);
    chk("wrap_s0_an",   an,         3'b110);
    chk("wrap_s0_tick", frame_tick, 1'b1);

    // Raw write, then an out-of-range address
    wr_digit(2'd1, 8'hA5, 1'b0);
    wr_digit(2'd3, 8'h00, 1'b0);
    wait_tick("tick_raw");
    chk("raw_s0_sseg", sseg, 8'h92);
    step(16);
    chk("raw_s1_an",   an,   3'b101);
    chk("raw_s1_sseg", sseg, 8'hA5);
    step(16);
    chk("raw_s2_sseg", sseg, 8'h08);

    // Frame tick period
    wait_tick("tick_period_start");
    ticks = 0;
    first = -1;
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i + 1;
      end
    end
    chk("tick_count", ticks, 3);
    chk("tick_first", first, 48);

    // Brightness
    bright = 2'd1;
    wait_tick("tick_b1");
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (an !== 3'b111) lit++;
      @(negedge clk);
    end
    chk("bright1_lit", lit, 4);

    bright = 2'd0;
    wait_tick("tick_b0");
    lit = 0;
    for (int i = 0; i < 48; i++) begin
      if (an !== 3'b111) lit++;
      @(negedge clk);
    end
    chk("bright0_lit", lit, 0);

    bright = 2'd3;
    wait_tick("tick_b3");
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (an !== 3'b111) lit++;
      @(negedge clk);
    end
    chk("bright3_lit", lit, 16);

    // Blanking
    blank = 3'b010;
    wait_tick("tick_blank");
    chk("blank_s0_an",   an,   3'b110);
    chk("blank_s0_sseg", sseg, 8'h92);
    step(16);
    chk("blank_s1_an",   an,   3'b111);
    chk("blank_s1_sseg", sseg, 8'hFF);
    step(16);
    chk("blank_s2_an",   an,   3'b011);
    chk("blank_s2_sseg", sseg, 8'h08);
    blank = '0;

    // Live update of the displayed digit: hex 3 without dp -> 8'hB0
    wait_tick("tick_live");
    chk("live_before", sseg, 8'h92);
    wr_digit(2'd0, 8'h03, 1'b1);
    chk("live_no_tear", {31'b0, (sseg === 8'h92) || (sseg === 8'hB0)}, 32'd1);
    step(1);
    chk("live_after2", sseg, 8'hB0);
    chk("live_an",     an,   3'b110);

    two_low = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if ($countones(~an) > 1) two_low = 1;
    end
    chk("an_onehot", {31'b0, two_low}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
